led_result: RTL and testbench
=============================

LED_RESULT -- requirements
Module: led_result

Interface
REQ-001 SHALL have parameter BLINK_TICKS, default 2000, meaning tick_i strobes per blink half-period (100 ms at 20 kHz).
REQ-002 SHALL have parameter BLINK_COUNT, default 3, meaning the number of full on/off blink periods shown after a stop.
REQ-003 SHALL have port clk_i  input  1  system clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port tick_i  input  1  single-cycle timebase strobe (20 kHz), the same strobe that drives the wheel.
REQ-006 SHALL have port pos_i  input  3  current wheel position, taken from the wheel's pos_o.
REQ-007 SHALL have port running_i  input  1  wheel-spinning flag, taken from the wheel's running_o.
REQ-008 SHALL have port led_o  output  8  LED drive, where bit n lights LED n.
REQ-009 SHALL have port win_o  output  1  set high while the final result is held steady.

Function
REQ-010 SHALL implement an FSM with four states: IDLE, RUN, BLINK and HOLD.
REQ-011 IDLE SHALL drive led_o=0 and win_o=0, and SHALL move to RUN on the first clock with running_i=1.
REQ-012 RUN SHALL drive led_o as the one-hot decode of pos_i, registered with one clk_i of latency from a pos_i change.
REQ-013 SHALL register running_i into running_q, and SHALL detect a stop as running_q=1 and running_i=0.
REQ-014 On a stop in RUN, SHALL latch pos_i of that same cycle into res_q, clear the tick and toggle counters, enter BLINK with phase ON, and drive led_o=one-hot(res_q) on the next clock.
REQ-015 BLINK SHALL count tick_i strobes only; when BLINK_TICKS strobes have been counted, it SHALL invert the phase and clear the tick counter.
REQ-016 BLINK SHALL drive led_o=one-hot(res_q) in phase ON and led_o=0 in phase OFF.
REQ-017 After 2*BLINK_COUNT phase inversions, BLINK SHALL enter HOLD with the phase ending ON.
REQ-018 HOLD SHALL drive led_o=one-hot(res_q) and win_o=1 steadily, with no timeout.
REQ-019 In BLINK or HOLD, running_i=1 SHALL move the FSM to RUN on the next clock, clear win_o, and abandon the blink.
REQ-020 When running_i rises in the same cycle as a phase toggle, the restart SHALL take priority over the toggle.
REQ-021 A stop detected outside RUN SHALL be ignored; for example, running_i falling in IDLE has no effect.
REQ-022 tick_i SHALL be ignored in the IDLE, RUN and HOLD states.
REQ-023 The tick counter SHALL be $clog2(BLINK_TICKS+1) bits wide, the toggle counter SHALL be $clog2(2*BLINK_COUNT+1) bits wide, and neither counter SHALL wrap.
REQ-024 led_o and win_o SHALL come directly from registers, with no combinational path from any input.

Reset
REQ-025 While rst_i=1, the block SHALL force state=IDLE, led_o=0, win_o=0, res_q=0, running_q=0 and both counters to 0, immediately and without waiting for a clock edge.
REQ-026 If rst_i is asserted mid-BLINK or mid-HOLD, the block SHALL abort to IDLE; after release it SHALL wait for running_i=1.

Configuration
REQ-027 SHALL support the macro LED_RESULT_TRAIL_EN; when it is defined, RUN SHALL drive led_o with both the current position and the previous position (a two-LED trail), where the previous position is pos_i registered on the last pos_i change.
REQ-028 When LED_RESULT_TRAIL_EN is undefined, RUN SHALL drive a single one-hot LED; BLINK, HOLD and IDLE behave identically with or without the macro.

Verification
Bench parameters for all scenarios: BLINK_TICKS=4, BLINK_COUNT=2, tick_i every 10 clocks.

REQ-029 Reset: assert rst_i mid-clock-period -> led_o=00000000 and win_o=0 before the next clock edge.
REQ-030 Run: raise running_i, step pos_i through 0..7 -> led_o follows 00000001..10000000, each one clock after the pos_i change.
REQ-031 Stop: drop running_i while pos_i=5 -> the blink shows 00100000 for 4 ticks, then 0 for 4 ticks, repeated twice; then HOLD with led_o=00100000 and win_o=1.
REQ-032 Restart: raise running_i during the second OFF phase (pos_i=2) -> the next clock is in RUN with led_o=00000100 and win_o=0.
REQ-033 Simultaneous events: raise running_i in the same cycle as a phase-toggle tick -> RUN is entered and no extra toggle occurs.
REQ-034 Trail: with LED_RESULT_TRAIL_EN defined, pos_i 3->4 -> led_o=00011000; with the macro undefined -> led_o=00010000.

Source files
------------

// File: rtl/led_result_if.sv
// Wheel-to-LED result bus: the position and run flag in, the LED drive and win flag out.
interface led_result_if;
  logic       tick_i;
  logic [2:0] pos_i;
  logic       running_i;
  logic [7:0] led_o;
  logic       win_o;

  modport master (
    output tick_i,
    output pos_i,
    output running_i,
    input  led_o,
    input  win_o
  );

  modport slave (
    input  tick_i,
    input  pos_i,
    input  running_i,
    output led_o,
    output win_o
  );
endinterface

// File: rtl/led_result.sv
// Result display for the LED wheel: follow, blink the stop position, then hold it.
// Optional LED_RESULT_TRAIL_EN adds a two-LED trail while the wheel runs.
module led_result #(
  parameter int BLINK_TICKS = 2000,
  parameter int BLINK_COUNT = 3
) (
  input logic         clk_i,
  input logic         rst_i,
  led_result_if.slave io
);

  localparam int TW = $clog2(BLINK_TICKS + 1);
  localparam int CW = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_TICKS - 1);
  localparam logic [CW-1:0] TOG_LAST  = CW'(2 * BLINK_COUNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BLINK = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state_q;
  logic          running_q;
  logic [2:0]    res_q;
  logic [TW-1:0] tick_q;
  logic [CW-1:0] tog_q;
  logic          phase_q;
  logic [7:0]    led_q;
  logic          win_q;
  logic [7:0]    run_led;
  logic          stop;

  function automatic logic [7:0] dec(input logic [2:0] p);
    logic [7:0] one;
    one = 8'd1;
    return one << p;
  endfunction

  assign stop = running_q & ~io.running_i;

`ifdef LED_RESULT_TRAIL_EN
  logic [2:0] pos_q;
  logic [2:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q  <= 3'd0;
      prev_q <= 3'd0;
    end else if (io.pos_i != pos_q) begin
      prev_q <= pos_q;
      pos_q  <= io.pos_i;
    end
  end

  // On the cycle of a change pos_q still holds the position being left
  assign run_led = dec(io.pos_i)
                 | dec((io.pos_i != pos_q) ? pos_q : prev_q);
`else
  assign run_led = dec(io.pos_i);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      res_q     <= 3'd0;
      tick_q    <= '0;
      tog_q     <= '0;
      phase_q   <= 1'b0;
      led_q     <= 8'd0;
      win_q     <= 1'b0;
    end else begin
      running_q <= io.running_i;
      unique case (state_q)
        S_IDLE: begin
          led_q <= 8'd0;
          win_q <= 1'b0;
          if (io.running_i) begin
            state_q <= S_RUN;
            led_q   <= run_led;
          end
        end
        S_RUN: begin
          win_q <= 1'b0;
          if (stop) begin
            state_q <= S_BLINK;
            res_q   <= io.pos_i;
            tick_q  <= '0;
            tog_q   <= '0;
            phase_q <= 1'b1;
            led_q   <= dec(io.pos_i);
          end else begin
            led_q <= run_led;
          end
        end
        S_BLINK: begin
          // A restart wins over a phase toggle on the same cycle
          if (io.running_i) begin
            state_q <= S_RUN;
            win_q   <= 1'b0;
            led_q   <= run_led;
          end else if (io.tick_i) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              phase_q <= ~phase_q;
              tog_q   <= tog_q + CW'(1);
              if (tog_q == TOG_LAST) begin
                state_q <= S_HOLD;
                win_q   <= 1'b1;
                led_q   <= dec(res_q);
              end else begin
                led_q <= phase_q ? 8'd0 : dec(res_q);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_HOLD: begin
          if (io.running_i) begin
            state_q <= S_RUN;
            win_q   <= 1'b0;
            led_q   <= run_led;
          end else begin
            win_q <= 1'b1;
            led_q <= dec(res_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.led_o = led_q;
  assign io.win_o = win_q;

endmodule

// File: tb/tb_led_result.sv
// Directed bench for led_result with BLINK_TICKS=4, BLINK_COUNT=2, tick every 10 clocks.
module tb_led_result;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   tcnt = 0;

`ifdef LED_RESULT_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  led_result_if bus ();

  led_result #(
    .BLINK_TICKS(4),
    .BLINK_COUNT(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int p);
    logic [7:0] one;
    one = 8'd1;
    return one << p[2:0];
  endfunction

  function automatic logic [7:0] run_exp(input int cur, input int prev);
    return TRAIL ? (oh(cur) | oh(prev)) : oh(cur);
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
    tcnt = (tcnt + 1) % 10;
    bus.tick_i = (tcnt == 0);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [7:0] led_e,
                      input logic win_e);
    chk({tag, "_led"}, bus.led_o, led_e);
    chk({tag, "_win"}, {7'd0, bus.win_o}, {7'd0, win_e});
  endtask

  task automatic wait_ticks(input int n, input string tag);
    int k = 0;
    int c = 0;
    logic t;
    while (k < n && c < 200) begin
      t = bus.tick_i;
      clk1();
      if (t) k++;
      c++;
    end
    checks++;
    assert (k == n) else begin
      errs++;
      $error("FAIL %s_timeout observed=%0d ticks expected=%0d", tag, k, n);
    end
  endtask

  initial begin
    int c;
    bus.tick_i    = 1'b0;
    bus.pos_i     = 3'd0;
    bus.running_i = 1'b0;

    // Reset state
    clk1();
    chk2("reset", 8'h00, 1'b0);
    rst = 1'b0;
    clk1();
    clk1();
    chk2("idle", 8'h00, 1'b0);

    // Run: follow the position one clock after each change
    bus.running_i = 1'b1;
    clk1();
    chk2("run0", run_exp(0, 0), 1'b0);
    for (int p = 1; p < 8; p++) begin
      bus.pos_i = 3'(p);
      clk1();
      chk("run_step", bus.led_o, run_exp(p, p - 1));
    end

    // Stop at position 5 and watch the blink
    bus.pos_i = 3'd5;
    clk1();
    bus.running_i = 1'b0;
    clk1();
    chk2("blink_on1", 8'h20, 1'b0);
    wait_ticks(3, "on1_mid");
    chk("on1_mid", bus.led_o, 8'h20);
    wait_ticks(1, "off1");
    chk("off1", bus.led_o, 8'h00);
    wait_ticks(3, "off1_mid");
    chk("off1_mid", bus.led_o, 8'h00);
    wait_ticks(1, "on2");
    chk("on2", bus.led_o, 8'h20);
    wait_ticks(4, "off2");
    chk2("off2", 8'h00, 1'b0);
    wait_ticks(4, "hold");
    chk2("hold", 8'h20, 1'b1);
    wait_ticks(8, "hold_stay");
    chk2("hold_stay", 8'h20, 1'b1);

    // Asynchronous reset in the middle of a clock period while holding
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk2("async_rst", 8'h00, 1'b0);
    clk1();
    rst = 1'b0;
    bus.pos_i = 3'd0;
    clk1();
    clk1();
    chk2("post_rst_idle", 8'h00, 1'b0);

    // Restart during the second OFF phase
    bus.running_i = 1'b1;
    clk1();
    bus.pos_i = 3'd5;
    clk1();
    bus.running_i = 1'b0;
    clk1();
    chk2("blink2_on1", 8'h20, 1'b0);
    wait_ticks(4, "b2_off1");
    bus.pos_i = 3'd2;
    wait_ticks(4, "b2_on2");
    chk("b2_on2", bus.led_o, 8'h20);
    wait_ticks(4, "b2_off2");
    chk("b2_off2", bus.led_o, 8'h00);
    wait_ticks(1, "b2_off2_in");
    bus.running_i = 1'b1;
    clk1();
    chk2("restart", run_exp(2, 5), 1'b0);

    // Restart on the very tick that would end the blink
    bus.running_i = 1'b0;
    clk1();
    chk2("blink3_on1", 8'h04, 1'b0);
    wait_ticks(12, "b3_off2");
    chk("b3_off2", bus.led_o, 8'h00);
    wait_ticks(3, "b3_pre");
    c = 0;
    while (!bus.tick_i && c < 20) begin
      clk1();
      c++;
    end
    bus.running_i = 1'b1;
    bus.pos_i = 3'd6;
    clk1();
    chk2("simul", run_exp(6, 2), 1'b0);
    clk1();
    chk2("simul_stay", run_exp(6, 2), 1'b0);

    // A fresh blink after the simultaneous restart runs its full length
    bus.running_i = 1'b0;
    clk1();
    chk2("blink4_on1", 8'h40, 1'b0);
    wait_ticks(3, "b4_on1_mid");
    chk("b4_on1_mid", bus.led_o, 8'h40);
    wait_ticks(1, "b4_off1");
    chk("b4_off1", bus.led_o, 8'h00);
    wait_ticks(12, "b4_hold");
    chk2("b4_hold", 8'h40, 1'b1);
    bus.running_i = 1'b1;
    clk1();
    chk2("hold_restart", run_exp(6, 2), 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
